// File: rtl/alarm_controller.sv
// alarm_controller: buzzer sequencer with arming, ring timeout, bounded snooze and dismiss.
// Define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off buzzer pattern while ringing.
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int SNOOZE_MAX  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic [4:0] time_hours,
    input  logic [5:0] time_minutes,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       arm,
    input  logic       adjusting,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzzer_en,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_cnt
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RINGING   = 2'd1,
        S_SNOOZE    = 2'd2,
        S_DISMISSED = 2'd3
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
    localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SECS - 1);
    localparam logic [2:0] SNZ_MAX   = 3'(SNOOZE_MAX);

    state_t     state_q, state_d;
    logic [7:0] ring_timer_q, ring_timer_d;
    logic [9:0] snz_timer_q, snz_timer_d;
    logic [2:0] snooze_cnt_q, snooze_cnt_d;
    logic       match, match_q, trig;

    // Only a rising match triggers, so a dismissed alarm cannot re-fire within its minute.
    assign match = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
    assign trig  = match & ~match_q & arm & ~adjusting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ring_timer_q <= 8'd0;
            snz_timer_q  <= 10'd0;
            snooze_cnt_q <= 3'd0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_timer_q <= ring_timer_d;
            snz_timer_q  <= snz_timer_d;
            snooze_cnt_q <= snooze_cnt_d;
            match_q      <= match;
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_timer_d = ring_timer_q;
        snz_timer_d  = snz_timer_q;
        snooze_cnt_d = snooze_cnt_q;
        if (!arm) begin
            state_d      = S_IDLE;
            ring_timer_d = 8'd0;
            snz_timer_d  = 10'd0;
            snooze_cnt_d = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        state_d      = S_RINGING;
                        ring_timer_d = 8'd0;
                        snooze_cnt_d = 3'd0;
                    end
                end
                S_RINGING: begin
                    // Exit events take precedence over a coincident tick.
                    if (dismiss) begin
                        state_d = S_DISMISSED;
                    end else if (snooze) begin
                        if (snooze_cnt_q < SNZ_MAX) begin
                            state_d      = S_SNOOZE;
                            snooze_cnt_d = snooze_cnt_q + 3'd1;
                            snz_timer_d  = 10'd0;
                        end else begin
                            state_d = S_DISMISSED;
                        end
                    end else if (sec_tick) begin
                        if (ring_timer_q >= RING_LAST) begin
                            state_d = S_DISMISSED;
                        end else if (ring_timer_q != 8'hFF) begin
                            ring_timer_d = ring_timer_q + 8'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (dismiss) begin
                        state_d = S_DISMISSED;
                    end else if (sec_tick) begin
                        if (snz_timer_q >= SNZ_LAST) begin
                            state_d      = S_RINGING;
                            ring_timer_d = 8'd0;
                        end else if (snz_timer_q != 10'h3FF) begin
                            snz_timer_d = snz_timer_q + 10'd1;
                        end
                    end
                end
                S_DISMISSED: begin
                    if (!match) begin
                        state_d      = S_IDLE;
                        snooze_cnt_d = 3'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    logic phase_q, phase_d;

    // Phase restarts high on every entry to RINGING, then flips once per second.
    always_comb begin
        phase_d = phase_q;
        if (state_d == S_RINGING && state_q != S_RINGING) begin
            phase_d = 1'b1;
        end else if (state_q == S_RINGING && sec_tick) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    always_comb begin
        ringing    = (state_q == S_RINGING);
        snoozing   = (state_q == S_SNOOZE);
        snooze_cnt = snooze_cnt_q;
`ifdef ALARM_BEEP_PATTERN_EN
        buzzer_en  = (state_q == S_RINGING) & phase_q;
`else
        buzzer_en  = (state_q == S_RINGING);
`endif
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with RING_SECS=4, SNOOZE_SECS=3, SNOOZE_MAX=2.
// Observed vector is {buzzer_en, ringing, snoozing, snooze_cnt[2:0]}.
module tb_alarm_controller;

`ifdef ALARM_BEEP_PATTERN_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sec_tick;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       arm;
  logic       adjusting;
  logic       snooze;
  logic       dismiss;
  logic       buzzer_en;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_cnt;
  logic [5:0] obs;
  logic [5:0] exp_v;

  int checks;
  int errors;

  assign obs = {buzzer_en, ringing, snoozing, snooze_cnt};

  alarm_controller #(
    .RING_SECS  (4),
    .SNOOZE_SECS(3),
    .SNOOZE_MAX (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sec_tick     (sec_tick),
    .time_hours   (time_hours),
    .time_minutes (time_minutes),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .arm          (arm),
    .adjusting    (adjusting),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .buzzer_en    (buzzer_en),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_cnt   (snooze_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 ns after a rising edge, outputs are read there too
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1;
    step(1);
    dismiss = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL reset_state: got %b exp %b", obs, 6'b000000); end
    rst_n = 1'b1;
    arm = 1'b1;
    step(1);
    time_minutes = 6'd30;
    step(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL reset_pre_ring: got %b exp %b", obs, 6'b110000); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL reset_async: got %b exp %b", obs, 6'b000000); end
    arm = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL reset_rel_unarmed: got %b exp %b", obs, 6'b000000); end
    rst_n = 1'b0;
    arm = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL reset_rel_armed: got %b exp %b", obs, 6'b110000); end
    pulse_dismiss();
    time_minutes = 6'd29;
    step(2);
  endtask

  task automatic test_timeout();
    time_minutes = 6'd30;
    step(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL to_ring: got %b exp %b", obs, 6'b110000); end
    for (int k = 1; k <= 3; k++) begin
      pulse_tick();
      exp_v = {(BEEP ? (k % 2 == 0) : 1'b1), 1'b1, 1'b0, 3'd0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL to_tick%0d: got %b exp %b", k, obs, exp_v); end
    end
    pulse_tick();
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL to_expire: got %b exp %b", obs, 6'b000000); end
    step(5);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL to_held_no_rering: got %b exp %b", obs, 6'b000000); end
    time_minutes = 6'd31;
    step(1);
    time_minutes = 6'd30;
    step(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL to_idle_rearm: got %b exp %b", obs, 6'b110000); end
    pulse_dismiss();
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL to_dismiss: got %b exp %b", obs, 6'b000000); end
    time_minutes = 6'd29;
    step(2);
  endtask

  task automatic test_snooze();
    time_minutes = 6'd30;
    step(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL snz_ring: got %b exp %b", obs, 6'b110000); end
    pulse_snooze();
    checks++;
    if (obs !== 6'b001001) begin errors++; $display("FAIL snz_first: got %b exp %b", obs, 6'b001001); end
    pulse_tick();
    pulse_tick();
    pulse_snooze();
    checks++;
    if (obs !== 6'b001001) begin errors++; $display("FAIL snz_ignore: got %b exp %b", obs, 6'b001001); end
    pulse_tick();
    checks++;
    if (obs !== 6'b110001) begin errors++; $display("FAIL snz_rering: got %b exp %b", obs, 6'b110001); end
    pulse_snooze();
    checks++;
    if (obs !== 6'b001010) begin errors++; $display("FAIL snz_second: got %b exp %b", obs, 6'b001010); end
    time_minutes = 6'd31;
    pulse_tick();
    pulse_tick();
    pulse_tick();
    checks++;
    if (obs !== 6'b110010) begin errors++; $display("FAIL snz_rering_no_match: got %b exp %b", obs, 6'b110010); end
    pulse_snooze();
    checks++;
    if (obs !== 6'b000010) begin errors++; $display("FAIL snz_limit_dismiss: got %b exp %b", obs, 6'b000010); end
    step(1);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL snz_cnt_clear: got %b exp %b", obs, 6'b000000); end
    time_minutes = 6'd29;
    step(1);
  endtask

  task automatic test_priority();
    time_minutes = 6'd30;
    step(1);
    pulse_snooze();
    pulse_tick();
    pulse_tick();
    pulse_tick();
    checks++;
    if (obs !== 6'b110001) begin errors++; $display("FAIL pri_rering: got %b exp %b", obs, 6'b110001); end
    sec_tick = 1'b1;
    snooze = 1'b1;
    dismiss = 1'b1;
    step(1);
    sec_tick = 1'b0;
    snooze = 1'b0;
    dismiss = 1'b0;
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("FAIL pri_dismiss_wins: got %b exp %b", obs, 6'b000001); end
    time_minutes = 6'd31;
    step(1);
    time_minutes = 6'd30;
    step(1);
    pulse_snooze();
    checks++;
    if (obs !== 6'b001001) begin errors++; $display("FAIL pri_snoozing: got %b exp %b", obs, 6'b001001); end
    arm = 1'b0;
    step(1);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL pri_disarm: got %b exp %b", obs, 6'b000000); end
    arm = 1'b1;
    step(2);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL pri_rearm_no_edge: got %b exp %b", obs, 6'b000000); end
    time_minutes = 6'd31;
    step(1);
    time_minutes = 6'd30;
    step(1);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    sec_tick = 1'b1;
    snooze = 1'b1;
    step(1);
    sec_tick = 1'b0;
    snooze = 1'b0;
    checks++;
    if (obs !== 6'b001001) begin errors++; $display("FAIL pri_snooze_over_timeout: got %b exp %b", obs, 6'b001001); end
    pulse_dismiss();
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("FAIL pri_dismiss_in_snooze: got %b exp %b", obs, 6'b000001); end
    time_minutes = 6'd29;
    step(2);
  endtask

  task automatic test_adjust();
    adjusting = 1'b1;
    step(1);
    time_minutes = 6'd30;
    step(2);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL adj_suppressed: got %b exp %b", obs, 6'b000000); end
    adjusting = 1'b0;
    step(2);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL adj_no_late_trig: got %b exp %b", obs, 6'b000000); end
    time_minutes = 6'd29;
    step(1);
    time_minutes = 6'd30;
    step(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL adj_trig: got %b exp %b", obs, 6'b110000); end
    adjusting = 1'b1;
    pulse_tick();
    exp_v = {(BEEP ? 1'b0 : 1'b1), 1'b1, 1'b0, 3'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL adj_ring_continues: got %b exp %b", obs, exp_v); end
    adjusting = 1'b0;
    pulse_dismiss();
    time_minutes = 6'd29;
    step(2);
  endtask

  task automatic test_alarm_edit();
    alarm_minutes = 6'd29;
    step(1);
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL edit_trig: got %b exp %b", obs, 6'b110000); end
    pulse_dismiss();
    alarm_minutes = 6'd30;
    step(2);
    time_hours = 5'd8;
    time_minutes = 6'd30;
    step(2);
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL hours_mismatch: got %b exp %b", obs, 6'b000000); end
    time_hours = 5'd7;
    time_minutes = 6'd29;
    step(1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    sec_tick      = 1'b0;
    time_hours    = 5'd7;
    time_minutes  = 6'd29;
    alarm_hours   = 5'd7;
    alarm_minutes = 6'd30;
    arm           = 1'b0;
    adjusting     = 1'b0;
    snooze        = 1'b0;
    dismiss       = 1'b0;
    exp_v         = 6'd0;

    test_reset();
    test_timeout();
    test_snooze();
    test_priority();
    test_adjust();
    test_alarm_edit();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
